// File: rtl/mandelbrot_render_scheduler.sv
// Mandelbrot render scheduler: dispatches batches of pixel coordinates to LANES
// point-generator lanes, captures their iteration counts into a ping-pong pair
// of result buffers and streams the results out in raster order.
module mandelbrot_render_scheduler #(
  parameter int unsigned LANES   = 16,
  parameter int unsigned HBI     = 32,
  parameter int unsigned COORD_W = 12,
  parameter int unsigned PIX_W   = 24
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     start_render,
  input  logic                     abort,
  input  logic [COORD_W-1:0]       cfg_x_size,
  input  logic [COORD_W-1:0]       cfg_y_size,
  output logic [LANES-1:0]         lane_start,
  output logic [LANES*COORD_W-1:0] lane_x,
  output logic [LANES*COORD_W-1:0] lane_y,
  input  logic [LANES-1:0]         lane_done,
  input  logic [LANES*HBI-1:0]     lane_iter,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [HBI-1:0]           out_data,
  output logic [PIX_W-1:0]         out_pixel,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned CntW = $clog2(LANES + 1);
  localparam int unsigned IdxW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {StIdle, StDispatch, StWait, StFlush} state_e;

  state_e               state_q;
  logic [COORD_W-1:0]   x_size_q, cur_x_q, cur_y_q;
  logic [PIX_W-1:0]     total_q, base_q, batch_base_q;
  logic [CntW-1:0]      batch_cnt_q;
  logic [LANES-1:0]     active_q, done_q, lane_start_q;
  logic [LANES*COORD_W-1:0] lane_x_q, lane_y_q;
  logic                 busy_q, frame_done_q;
  logic [1:0]           full_q;
  logic                 wr_sel_q, rd_sel_q;
  logic [IdxW-1:0]      rd_off_q;
  logic [PIX_W-1:0]     buf_base_q [2];
  logic [CntW-1:0]      buf_cnt_q [2];
  logic [HBI-1:0]       buf_data_q [2][LANES];

  logic [PIX_W-1:0]     cfg_total, rem;
  logic [CntW-1:0]      disp_cnt;
  logic [LANES-1:0]     act_mask, done_now;
  logic [LANES*COORD_W-1:0] walk_x_all, walk_y_all;
  logic [COORD_W-1:0]   walk_x, walk_y, x_last;
  logic                 all_done, fire, last_entry, wr_free, capture;

  assign cfg_total = PIX_W'(cfg_x_size) * PIX_W'(cfg_y_size);
  assign x_last    = x_size_q - COORD_W'(1);

  // Walk the (x,y) counter across the batch; the final value seeds the next batch.
  always_comb begin
    walk_x     = cur_x_q;
    walk_y     = cur_y_q;
    walk_x_all = '0;
    walk_y_all = '0;
    act_mask   = '0;
    for (int i = 0; i < LANES; i++) begin
      walk_x_all[i*COORD_W +: COORD_W] = walk_x;
      walk_y_all[i*COORD_W +: COORD_W] = walk_y;
      act_mask[i] = (base_q + PIX_W'(i)) < total_q;
      if (walk_x == x_last) begin
        walk_x = '0;
        walk_y = walk_y + COORD_W'(1);
      end else begin
        walk_x = walk_x + COORD_W'(1);
      end
    end
  end

  // Batch size, completion detection and buffer hand-off decisions.
  always_comb begin
    rem        = total_q - base_q;
    disp_cnt   = (rem >= PIX_W'(LANES)) ? CntW'(LANES) : CntW'(rem);
    // A lane's done is stale while its start pulse is still out.
    done_now   = done_q | (lane_done & ~lane_start_q);
    all_done   = &(done_now | ~active_q);
    out_valid  = full_q[rd_sel_q];
    fire       = out_valid & out_ready;
    last_entry = CntW'(rd_off_q) == (buf_cnt_q[rd_sel_q] - CntW'(1));
    // A buffer whose last entry leaves this cycle may be refilled this cycle.
    wr_free    = !full_q[wr_sel_q] || (fire && last_entry && (rd_sel_q == wr_sel_q));
    capture    = (state_q == StWait) && all_done && wr_free && !abort;
    out_data   = out_valid ? buf_data_q[rd_sel_q][rd_off_q] : '0;
    out_pixel  = out_valid ? buf_base_q[rd_sel_q] + PIX_W'(rd_off_q) : '0;
  end

  assign lane_start = lane_start_q;
  assign lane_x     = lane_x_q;
  assign lane_y     = lane_y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

  // Dispatch FSM, drain pointers and buffer bookkeeping.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q      <= StIdle;
      x_size_q     <= '0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      total_q      <= '0;
      base_q       <= '0;
      batch_base_q <= '0;
      batch_cnt_q  <= '0;
      active_q     <= '0;
      done_q       <= '0;
      lane_start_q <= '0;
      lane_x_q     <= '0;
      lane_y_q     <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      full_q       <= '0;
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      rd_off_q     <= '0;
      for (int b = 0; b < 2; b++) begin
        buf_base_q[b] <= '0;
        buf_cnt_q[b]  <= '0;
      end
    end else begin
      lane_start_q <= '0;
      frame_done_q <= 1'b0;
      if (fire) begin
        if (last_entry) begin
          full_q[rd_sel_q] <= 1'b0;
          rd_sel_q         <= ~rd_sel_q;
          rd_off_q         <= '0;
        end else begin
          rd_off_q <= rd_off_q + IdxW'(1);
        end
      end
      if (capture) begin
        full_q[wr_sel_q]     <= 1'b1;
        buf_base_q[wr_sel_q] <= batch_base_q;
        buf_cnt_q[wr_sel_q]  <= batch_cnt_q;
        wr_sel_q             <= ~wr_sel_q;
      end
      case (state_q)
        StIdle: begin
          if (start_render && !abort) begin
            if (cfg_total == '0) begin
              frame_done_q <= 1'b1;
            end else begin
              x_size_q <= cfg_x_size;
              total_q  <= cfg_total;
              base_q   <= '0;
              cur_x_q  <= '0;
              cur_y_q  <= '0;
              busy_q   <= 1'b1;
              state_q  <= StDispatch;
            end
          end
        end
        StDispatch: begin
          lane_start_q <= act_mask;
          active_q     <= act_mask;
          done_q       <= '0;
          lane_x_q     <= walk_x_all;
          lane_y_q     <= walk_y_all;
          cur_x_q      <= walk_x;
          cur_y_q      <= walk_y;
          batch_base_q <= base_q;
          batch_cnt_q  <= disp_cnt;
          base_q       <= base_q + PIX_W'(LANES);
          state_q      <= StWait;
        end
        StWait: begin
          done_q <= done_now;
          if (capture) state_q <= (base_q < total_q) ? StDispatch : StFlush;
        end
        StFlush: begin
          if (full_q == 2'b00) begin
            frame_done_q <= 1'b1;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      if (abort && (state_q != StIdle)) begin
        state_q      <= StIdle;
        busy_q       <= 1'b0;
        frame_done_q <= 1'b0;
        lane_start_q <= '0;
        full_q       <= '0;
        wr_sel_q     <= 1'b0;
        rd_sel_q     <= 1'b0;
        rd_off_q     <= '0;
      end
    end
  end

  // Result storage: copy the active lanes' counts into the selected buffer.
  always_ff @(posedge CLK) begin
    if (capture) begin
      for (int i = 0; i < LANES; i++) begin
        if (active_q[i]) buf_data_q[wr_sel_q][i] <= lane_iter[i*HBI +: HBI];
      end
    end
  end

endmodule

// File: tb/tb_mandelbrot_render_scheduler.sv
// Bench for mandelbrot_render_scheduler: behavioural lanes, raster-order scoreboard.
module tb_mandelbrot_render_scheduler;
  localparam int LANES   = 4;
  localparam int HBI     = 32;
  localparam int COORD_W = 12;
  localparam int PIX_W   = 24;

  logic                     CLK = 1'b0;
  logic                     RST_N;
  logic                     start_render, abort, out_ready;
  logic [COORD_W-1:0]       cfg_x_size, cfg_y_size;
  logic [LANES-1:0]         lane_start;
  logic [LANES*COORD_W-1:0] lane_x, lane_y;
  logic [LANES-1:0]         lane_done = '0;
  logic [LANES*HBI-1:0]     lane_iter = '0;
  logic                     out_valid, busy, frame_done;
  logic [HBI-1:0]           out_data;
  logic [PIX_W-1:0]         out_pixel;

  always #5 CLK = ~CLK;

  mandelbrot_render_scheduler #(
    .LANES(LANES), .HBI(HBI), .COORD_W(COORD_W), .PIX_W(PIX_W)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .start_render(start_render), .abort(abort),
    .cfg_x_size(cfg_x_size), .cfg_y_size(cfg_y_size), .lane_start(lane_start),
    .lane_x(lane_x), .lane_y(lane_y), .lane_done(lane_done), .lane_iter(lane_iter),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_pixel(out_pixel), .busy(busy), .frame_done(frame_done)
  );

  typedef struct { int pix; logic [HBI-1:0] data; } exp_t;
  exp_t exp_q[$];

  int total_cnt = 0, bad_cnt = 0;
  int ncyc = 0, fd_count = 0, fd_base = 0;
  int cur_xs = 1, cur_total = 0, cur_batch = 0;
  int disp_cyc[64];
  bit lane_mode = 0, dly_rand = 0;
  int dly[LANES];
  int lcnt[LANES];
  bit stalled_prev = 0;
  logic [HBI-1:0]   prev_data;
  logic [PIX_W-1:0] prev_pix;
  bit valid_seen = 0;
  int first_valid = 0, acc3 = 0;

  function automatic logic [HBI-1:0] ref_iter(int lane, int x, int y);
    if (lane_mode) return HBI'(lane + 10);
    return HBI'(x * 131 + y * 7919 + 5);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Lane models plus output monitor, all sampled on the falling edge.
  always @(negedge CLK) begin
    logic [LANES-1:0] emask;
    int p, lx, ly;
    exp_t e;
    ncyc++;
    if (lane_start != '0) begin
      for (int i = 0; i < LANES; i++) emask[i] = (cur_batch * LANES + i) < cur_total;
      check("lane_start_mask", lane_start, emask);
      if (cur_batch < 64) disp_cyc[cur_batch] = ncyc;
      for (int i = 0; i < LANES; i++) begin
        if (lane_start[i]) begin
          p  = cur_batch * LANES + i;
          lx = int'(lane_x[i*COORD_W +: COORD_W]);
          ly = int'(lane_y[i*COORD_W +: COORD_W]);
          if (cur_xs != 0 && p < cur_total)
            check("lane_xy", {lx[31:0], ly[31:0]}, {p % cur_xs, p / cur_xs});
          lcnt[i] = dly_rand ? int'($urandom_range(1, 6)) : dly[i];
          lane_done[i] = 1'b0;
          lane_iter[i*HBI +: HBI] = ref_iter(i, lx, ly);
        end
      end
      cur_batch++;
    end
    for (int i = 0; i < LANES; i++) begin
      if (!lane_start[i] && lcnt[i] > 0) begin
        lcnt[i]--;
        if (lcnt[i] == 0) lane_done[i] = 1'b1;
      end
    end
    if (!RST_N || abort) stalled_prev = 0;
    else if (stalled_prev)
      check("stall_hold", {out_valid, out_data, out_pixel}, {1'b1, prev_data, prev_pix});
    if (out_valid && !valid_seen) begin
      valid_seen  = 1;
      first_valid = ncyc;
    end
    if (out_valid && out_ready && RST_N && !abort) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        bad_cnt++;
        $display("FAIL scoreboard_extra: got pixel %0d, nothing expected", out_pixel);
      end else begin
        e = exp_q.pop_front();
        check("out_pixel", out_pixel, e.pix);
        check("out_data", out_data, e.data);
        if (e.pix == 3) acc3 = ncyc;
      end
    end
    stalled_prev = RST_N && !abort && out_valid && !out_ready;
    prev_data    = out_data;
    prev_pix     = out_pixel;
    if (frame_done) fd_count++;
  end

  task automatic set_dly(input int a, input int b, input int c, input int d);
    dly[0] = a; dly[1] = b; dly[2] = c; dly[3] = d;
  endtask

  task automatic begin_frame(input int xs, input int ys);
    cur_xs = xs; cur_total = xs * ys; cur_batch = 0; valid_seen = 0;
    fd_base = fd_count;
    for (int p = 0; p < cur_total; p++) exp_q.push_back('{p, ref_iter(p % LANES, p % xs, p / xs)});
    cfg_x_size = COORD_W'(xs);
    cfg_y_size = COORD_W'(ys);
    start_render = 1'b1;
    @(posedge CLK); #1;
    start_render = 1'b0;
  endtask

  task automatic finish_frame(input bit rnd_ready);
    int n;
    n = 0;
    while (fd_count == fd_base && n < 3000) begin
      @(posedge CLK); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("frame_done_once", fd_count - fd_base, 1);
    check("sb_empty", exp_q.size(), 0);
    check("batch_count", cur_batch, (cur_total + LANES - 1) / LANES);
    check("busy_after", busy, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int xs, ys, fdb, nb;
    RST_N = 1'b0; start_render = 1'b0; abort = 1'b0; out_ready = 1'b1;
    cfg_x_size = '0; cfg_y_size = '0;
    for (int i = 0; i < LANES; i++) lcnt[i] = 0;
    set_dly(5, 5, 5, 5);
    repeat (3) @(posedge CLK);
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_lane_start", lane_start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_lane_xy", {lane_x, lane_y}, 0);
    check("rst_out", {out_data, out_pixel}, 0);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    // basic 3x2 frame
    begin_frame(3, 2);
    finish_frame(0);

    // out-of-order lane completion
    set_dly(9, 2, 7, 4);
    lane_mode = 1;
    begin_frame(4, 1);
    finish_frame(0);
    check("ooo_capture_time", first_valid - disp_cyc[0], 10);
    lane_mode = 0;

    // back-pressure, then coincident free and capture on release
    set_dly(1, 1, 1, 1);
    out_ready = 1'b0;
    begin_frame(4, 4);
    repeat (20) @(posedge CLK);
    #1;
    check("bp_batches", cur_batch, 3);
    check("bp_busy", busy, 1);
    check("bp_head", {out_valid, out_pixel}, {1'b1, 24'd0});
    out_ready = 1'b1;
    finish_frame(0);
    check("coincident_dispatch", disp_cyc[3] - acc3, 2);

    // random sizes, lane latencies and back-pressure
    dly_rand = 1;
    for (int k = 0; k < 6; k++) begin
      xs = int'($urandom_range(1, 9));
      ys = int'($urandom_range(1, 5));
      begin_frame(xs, ys);
      finish_frame(1);
    end
    dly_rand = 0;

    // abort mid-WAIT with output pending; start alongside abort is ignored
    set_dly(2, 2, 2, 2);
    out_ready = 1'b0;
    begin_frame(4, 4);
    repeat (12) @(posedge CLK);
    #1;
    check("abort_pre_valid", out_valid, 1);
    fdb = fd_count;
    nb  = cur_batch;
    abort = 1'b1; start_render = 1'b1;
    @(posedge CLK); #1;
    abort = 1'b0; start_render = 1'b0;
    check("abort_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    repeat (10) @(posedge CLK);
    #1;
    check("abort_no_done", fd_count, fdb);
    check("abort_no_dispatch", cur_batch, nb);
    check("abort_idle", {busy, out_valid}, 0);
    exp_q.delete();
    out_ready = 1'b1;

    // reset mid-frame, then a clean 2x2 frame
    set_dly(3, 3, 3, 3);
    begin_frame(4, 4);
    repeat (7) @(posedge CLK);
    #1;
    RST_N = 1'b0;
    @(posedge CLK); #1;
    check("mid_rst_ctrl", {busy, out_valid, frame_done, lane_start}, 0);
    check("mid_rst_out", {out_data, out_pixel}, 0);
    RST_N = 1'b1;
    exp_q.delete();
    @(posedge CLK); #1;
    begin_frame(2, 2);
    finish_frame(0);

    // degenerate 0x5: frame_done one cycle after start, nothing dispatched
    begin_frame(0, 5);
    check("zero_done", frame_done, 1);
    check("zero_busy", busy, 0);
    @(posedge CLK); #1;
    check("zero_done_pulse", frame_done, 0);
    finish_frame(0);

    // degenerate 1x1
    begin_frame(1, 1);
    finish_frame(0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
